// File: rtl/modbus_uart.sv
// modbus_uart: serial PHY for the MODBUS RTU slave endpoint.
// Holds a UART receiver, a UART transmitter and a bit-period tick generator on
// one clock. Line format: 8 data bits LSB first, optional parity, 1/2 stop bits,
// 16x oversampling.
//
// Ports:
//   clk         reference clock
//   reset       asynchronous active-high reset
//   rx          serial line in (asynchronous, idle high)
//   tx          serial line out (idle high)
//   txdata      byte to send, captured on the send rising edge
//   send        rising edge requests a transmission
//   txbusy      high while a TX frame is in progress
//   rxdata      last received byte
//   ready       one-clk pulse: rxdata holds a valid new byte
//   rxerr       one-clk pulse: framing or parity error
//   timeout_clk one-clk pulse once per bit period
module modbus_uart #(
    parameter int unsigned CLKDIV   = 27,
    parameter int unsigned PARITY   = 1,
    parameter int unsigned STOPBITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    input  logic [7:0] txdata,
    input  logic       send,
    output logic       txbusy,
    output logic [7:0] rxdata,
    output logic       ready,
    output logic       rxerr,
    output logic       timeout_clk
);

    localparam int unsigned DIV_W = 16;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKDIV - 1);

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_BREAK
    } rx_state_e;

    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA, T_PARITY, T_STOP
    } tx_state_e;

    // Tick generation
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       tmo_q, tmo_d;
    logic             timeout_clk_q, timeout_clk_d;
    logic             tick_c;

    // Receiver
    logic       rx_s1_q, rx_s2_q;
    rx_state_e  r_state_q, r_state_d;
    logic [3:0] r_phase_q, r_phase_d;
    logic [2:0] r_bit_q, r_bit_d;
    logic [7:0] r_shift_q, r_shift_d;
    logic       r_perr_q, r_perr_d;
    logic [7:0] rxdata_q, rxdata_d;
    logic       ready_q, ready_d;
    logic       rxerr_q, rxerr_d;
    logic       r_sample_c;
    logic       r_par_c;

    // Transmitter
    logic       send_q;
    logic       send_edge_c;
    tx_state_e  t_state_q, t_state_d;
    logic [3:0] t_phase_q, t_phase_d;
    logic [2:0] t_bit_q, t_bit_d;
    logic [7:0] t_byte_q, t_byte_d;
    logic       t_par_q, t_par_d;
    logic       tx_q, tx_d;
    logic       txbusy_q, txbusy_d;

    // Oversample tick and bit-period timeout pulse, both free running
    always_comb begin
        tick_c        = (div_q == DIV_MAX);
        div_d         = tick_c ? '0 : div_q + DIV_W'(1);
        tmo_d         = tick_c ? tmo_q + 4'd1 : tmo_q;
        timeout_clk_d = tick_c && (tmo_q == 4'hF);
    end

    // RX next state: start detect, mid-bit sampling, parity and stop checks
    always_comb begin
        r_state_d = r_state_q;
        r_phase_d = r_phase_q;
        r_bit_d   = r_bit_q;
        r_shift_d = r_shift_q;
        r_perr_d  = r_perr_q;
        rxdata_d  = rxdata_q;
        ready_d   = 1'b0;
        rxerr_d   = 1'b0;
        r_par_c   = (PARITY == 2) ? ~^r_shift_q : ^r_shift_q;
        // The start bit is sampled at mid-bit; every later bit 16 ticks on.
        r_sample_c = tick_c &&
                     (r_phase_q == ((r_state_q == R_START) ? 4'd7 : 4'd15));

        if (tick_c) begin
            case (r_state_q)
                R_IDLE: begin
                    if (!rx_s2_q) begin
                        r_state_d = R_START;
                        r_phase_d = 4'd0;
                    end
                end
                R_BREAK: begin
                    if (rx_s2_q) r_state_d = R_IDLE;
                end
                default: begin
                    if (r_sample_c) begin
                        r_phase_d = 4'd0;
                        case (r_state_q)
                            R_START: begin
                                if (rx_s2_q) begin
                                    r_state_d = R_IDLE;
                                end else begin
                                    r_state_d = R_DATA;
                                    r_bit_d   = 3'd0;
                                    r_perr_d  = 1'b0;
                                end
                            end
                            R_DATA: begin
                                r_shift_d = {rx_s2_q, r_shift_q[7:1]};
                                r_bit_d   = r_bit_q + 3'd1;
                                if (r_bit_q == 3'd7)
                                    r_state_d = (PARITY != 0) ? R_PARITY : R_STOP;
                            end
                            R_PARITY: begin
                                r_perr_d  = (rx_s2_q != r_par_c);
                                r_state_d = R_STOP;
                            end
                            R_STOP: begin
                                if (rx_s2_q) begin
                                    rxdata_d  = r_shift_q;
                                    ready_d   = ~r_perr_q;
                                    rxerr_d   = r_perr_q;
                                    r_state_d = R_IDLE;
                                end else begin
                                    // Framing error or break: one rxerr, then wait for idle
                                    rxerr_d   = 1'b1;
                                    r_state_d = R_BREAK;
                                end
                            end
                            default: r_state_d = R_IDLE;
                        endcase
                    end else begin
                        r_phase_d = r_phase_q + 4'd1;
                    end
                end
            endcase
        end
    end

    // TX next state: frame sequencing, 16 ticks per bit
    always_comb begin
        send_edge_c = send & ~send_q;
        t_state_d   = t_state_q;
        t_phase_d   = t_phase_q;
        t_bit_d     = t_bit_q;
        t_byte_d    = t_byte_q;
        t_par_d     = t_par_q;
        tx_d        = tx_q;
        txbusy_d    = txbusy_q;

        case (t_state_q)
            T_IDLE: begin
                if (send_edge_c) begin
                    t_byte_d  = txdata;
                    t_par_d   = (PARITY == 2) ? ~^txdata : ^txdata;
                    t_state_d = T_START;
                    t_phase_d = 4'd0;
                    t_bit_d   = 3'd0;
                    tx_d      = 1'b0;
                    txbusy_d  = 1'b1;
                end
            end
            default: begin
                if (tick_c) begin
                    if (t_phase_q == 4'd15) begin
                        t_phase_d = 4'd0;
                        case (t_state_q)
                            T_START: begin
                                t_state_d = T_DATA;
                                tx_d      = t_byte_q[0];
                                t_byte_d  = {1'b0, t_byte_q[7:1]};
                                t_bit_d   = 3'd0;
                            end
                            T_DATA: begin
                                if (t_bit_q == 3'd7) begin
                                    t_bit_d = 3'd0;
                                    if (PARITY != 0) begin
                                        t_state_d = T_PARITY;
                                        tx_d      = t_par_q;
                                    end else begin
                                        t_state_d = T_STOP;
                                        tx_d      = 1'b1;
                                    end
                                end else begin
                                    tx_d     = t_byte_q[0];
                                    t_byte_d = {1'b0, t_byte_q[7:1]};
                                    t_bit_d  = t_bit_q + 3'd1;
                                end
                            end
                            T_PARITY: begin
                                t_state_d = T_STOP;
                                tx_d      = 1'b1;
                                t_bit_d   = 3'd0;
                            end
                            T_STOP: begin
                                if ((STOPBITS == 2) && (t_bit_q == 3'd0)) begin
                                    t_bit_d = 3'd1;
                                end else begin
                                    t_state_d = T_IDLE;
                                    txbusy_d  = 1'b0;
                                    tx_d      = 1'b1;
                                end
                            end
                            default: begin
                                t_state_d = T_IDLE;
                                txbusy_d  = 1'b0;
                                tx_d      = 1'b1;
                            end
                        endcase
                    end else begin
                        t_phase_d = t_phase_q + 4'd1;
                    end
                end
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            tmo_q         <= 4'd0;
            timeout_clk_q <= 1'b0;
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            r_state_q     <= R_IDLE;
            r_phase_q     <= 4'd0;
            r_bit_q       <= 3'd0;
            r_shift_q     <= 8'd0;
            r_perr_q      <= 1'b0;
            rxdata_q      <= 8'd0;
            ready_q       <= 1'b0;
            rxerr_q       <= 1'b0;
            send_q        <= 1'b0;
            t_state_q     <= T_IDLE;
            t_phase_q     <= 4'd0;
            t_bit_q       <= 3'd0;
            t_byte_q      <= 8'd0;
            t_par_q       <= 1'b0;
            tx_q          <= 1'b1;
            txbusy_q      <= 1'b0;
        end else begin
            div_q         <= div_d;
            tmo_q         <= tmo_d;
            timeout_clk_q <= timeout_clk_d;
            rx_s1_q       <= rx;
            rx_s2_q       <= rx_s1_q;
            r_state_q     <= r_state_d;
            r_phase_q     <= r_phase_d;
            r_bit_q       <= r_bit_d;
            r_shift_q     <= r_shift_d;
            r_perr_q      <= r_perr_d;
            rxdata_q      <= rxdata_d;
            ready_q       <= ready_d;
            rxerr_q       <= rxerr_d;
            send_q        <= send;
            t_state_q     <= t_state_d;
            t_phase_q     <= t_phase_d;
            t_bit_q       <= t_bit_d;
            t_byte_q      <= t_byte_d;
            t_par_q       <= t_par_d;
            tx_q          <= tx_d;
            txbusy_q      <= txbusy_d;
        end
    end

    assign tx          = tx_q;
    assign txbusy      = txbusy_q;
    assign rxdata      = rxdata_q;
    assign ready       = ready_q;
    assign rxerr       = rxerr_q;
    assign timeout_clk = timeout_clk_q;

endmodule
